// File: rtl/char_write_ctrl.sv
// Character-buffer write controller: turns a host stream of printable/control codes into
// buffer writes with cursor tracking, row blanking on row advance and full-screen clear.
module char_write_ctrl #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 60,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_char,
  output logic                  o_ready,
  input  logic                  i_clear,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_adr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [6:0]            o_cur_col,
  output logic [5:0]            o_cur_row,
  output logic                  o_busy
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StClearRow = 2'd1;
  localparam logic [1:0] StClearAll = 2'd2;

  localparam logic [DATA_WIDTH-1:0] ChLf = DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] ChCr = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] ChBs = DATA_WIDTH'(8'h08);

  localparam logic [ADDR_WIDTH-1:0] AllLast = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ColsA   = ADDR_WIDTH'(COLS);
  localparam logic [6:0]            ColLast = 7'(COLS - 1);
  localparam logic [5:0]            RowLast = 6'(ROWS - 1);

  logic [1:0]            r_state, w_state_nxt;
  logic [6:0]            r_col, w_col_nxt;
  logic [5:0]            r_row, w_row_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_adr, w_clr_adr_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_last, w_clr_last_nxt;
  logic                  r_wr_en, w_wr_en_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_adr, w_wr_adr_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;

  logic [5:0]            w_row_adv;
  logic [ADDR_WIDTH-1:0] w_row_base;
  logic [ADDR_WIDTH-1:0] w_cur_adr;
  logic                  w_accept;

  assign o_ready    = (r_state == StIdle) && !i_clear;
  assign o_busy     = (r_state != StIdle);
  assign w_accept   = i_valid && o_ready;
  assign w_row_adv  = (r_row == RowLast) ? 6'd0 : r_row + 6'd1;
  assign w_row_base = ADDR_WIDTH'(w_row_adv) * ColsA;
  assign w_cur_adr  = ADDR_WIDTH'(r_row) * ColsA + ADDR_WIDTH'(r_col);

  always_comb begin
    w_state_nxt    = r_state;
    w_col_nxt      = r_col;
    w_row_nxt      = r_row;
    w_clr_adr_nxt  = r_clr_adr;
    w_clr_last_nxt = r_clr_last;
    w_wr_en_nxt    = 1'b0;
    w_wr_adr_nxt   = r_wr_adr;
    w_data_nxt     = r_data;
    if (i_clear) begin
      // Clear wins over everything, including a clear already in flight.
      w_state_nxt    = StClearAll;
      w_col_nxt      = 7'd0;
      w_row_nxt      = 6'd0;
      w_clr_adr_nxt  = '0;
      w_clr_last_nxt = AllLast;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            case (i_char)
              ChCr: w_col_nxt = 7'd0;
              ChLf: begin
                w_col_nxt      = 7'd0;
                w_row_nxt      = w_row_adv;
                w_clr_adr_nxt  = w_row_base;
                w_clr_last_nxt = w_row_base + ColsA - 1'b1;
                w_state_nxt    = StClearRow;
              end
              ChBs: begin
                if (r_col != 7'd0) begin
                  w_col_nxt    = r_col - 7'd1;
                  w_wr_en_nxt  = 1'b1;
                  w_wr_adr_nxt = w_cur_adr - 1'b1;
                  w_data_nxt   = '0;
                end
              end
              default: begin
                w_wr_en_nxt  = 1'b1;
                w_wr_adr_nxt = w_cur_adr;
                w_data_nxt   = i_char;
                if (r_col == ColLast) begin
                  w_col_nxt      = 7'd0;
                  w_row_nxt      = w_row_adv;
                  w_clr_adr_nxt  = w_row_base;
                  w_clr_last_nxt = w_row_base + ColsA - 1'b1;
                  w_state_nxt    = StClearRow;
                end else begin
                  w_col_nxt = r_col + 7'd1;
                end
              end
            endcase
          end
        end
        StClearRow, StClearAll: begin
          w_wr_en_nxt  = 1'b1;
          w_wr_adr_nxt = r_clr_adr;
          w_data_nxt   = '0;
          if (r_clr_adr == r_clr_last) begin
            w_state_nxt = StIdle;
          end else begin
            w_clr_adr_nxt = r_clr_adr + 1'b1;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_col      <= 7'd0;
      r_row      <= 6'd0;
      r_clr_adr  <= '0;
      r_clr_last <= '0;
      r_wr_en    <= 1'b0;
      r_wr_adr   <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_clr_adr  <= w_clr_adr_nxt;
      r_clr_last <= w_clr_last_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_adr   <= w_wr_adr_nxt;
      r_data     <= w_data_nxt;
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_adr  = r_wr_adr;
  assign o_data    = r_data;
  assign o_cur_col = r_col;
  assign o_cur_row = r_row;

endmodule

// File: tb/tb_char_write_ctrl.sv
// Directed bench for char_write_ctrl: character writes, control codes, row clear,
// full-screen clear with preemption, and reset during a clear.
module tb_char_write_ctrl;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [7:0]  chr;
  logic        ready;
  logic        clear;
  logic        wr_en;
  logic [12:0] wr_adr;
  logic [7:0]  data;
  logic [6:0]  cur_col;
  logic [5:0]  cur_row;
  logic        busy;

  int checks;
  int failures;

  char_write_ctrl #(
    .COLS       (80),
    .ROWS       (60),
    .ADDR_WIDTH (13),
    .DATA_WIDTH (8)
  ) u_dut (
    .i_sys_clk (clk),
    .i_rst_n   (rst_n),
    .i_valid   (valid),
    .i_char    (chr),
    .o_ready   (ready),
    .i_clear   (clear),
    .o_wr_en   (wr_en),
    .o_wr_adr  (wr_adr),
    .o_data    (data),
    .o_cur_col (cur_col),
    .o_cur_row (cur_row),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, then presents one code for exactly one edge.
  task automatic send(input logic [7:0] code);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      step();
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    valid = 1'b1;
    chr   = code;
    step();
    valid = 1'b0;
  endtask

  // Starting at the sample right after entering the row clear, expect n zero writes
  // from base upward with ready low for the whole sequence.
  task automatic chk_burst(input string tag, input int base, input int n);
    int bad_wr;
    int bad_rdy;
    bad_wr  = 0;
    bad_rdy = 0;
    for (int i = 0; i < n; i++) begin
      if (ready !== 1'b0) bad_rdy++;
      step();
      if (wr_en !== 1'b1 || wr_adr !== 13'(base + i) || data !== 8'h00) bad_wr++;
    end
    check({tag, "_writes"}, 32'(bad_wr), 32'd0);
    check({tag, "_ready_low"}, 32'(bad_rdy), 32'd0);
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
    step();
    check({tag, "_wr_en_after"}, 32'(wr_en), 32'd0);
  endtask

  initial begin
    int cnt;
    int bad;
    int lim;
    logic [12:0] last;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    valid    = 1'b0;
    chr      = 8'h00;
    clear    = 1'b0;
    #23;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_adr", 32'(wr_adr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_col", 32'(cur_col), 32'd0);
    check("rst_row", 32'(cur_row), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_ready", 32'(ready), 32'd1);

    // 'A' at (0,0)
    send(8'h41);
    check("a_wr_en", 32'(wr_en), 32'd1);
    check("a_adr", 32'(wr_adr), 32'd0);
    check("a_data", 32'(data), 32'h41);
    check("a_col", 32'(cur_col), 32'd1);
    check("a_row", 32'(cur_row), 32'd0);
    step();
    check("a_single_strobe", 32'(wr_en), 32'd0);

    // CR: column back to 0, no write
    send(8'h0D);
    check("cr_no_write", 32'(wr_en), 32'd0);
    check("cr_col", 32'(cur_col), 32'd0);

    // Walk to (2,79)
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 79; i++) send(8'h61);
    check("pos_col79", 32'(cur_col), 32'd79);
    check("pos_row2", 32'(cur_row), 32'd2);
    send(8'h42);
    check("eol_wr_en", 32'(wr_en), 32'd1);
    check("eol_adr", 32'(wr_adr), 32'd239);
    check("eol_data", 32'(data), 32'h42);
    check("eol_col", 32'(cur_col), 32'd0);
    check("eol_row", 32'(cur_row), 32'd3);
    chk_burst("eol_clr", 240, 80);

    // Walk to (59,5), then LF wraps to row 0
    for (int i = 0; i < 56; i++) send(8'h0A);
    check("pos_row59", 32'(cur_row), 32'd59);
    for (int i = 0; i < 5; i++) send(8'h62);
    check("pos_col5", 32'(cur_col), 32'd5);
    send(8'h0A);
    check("lf_no_write", 32'(wr_en), 32'd0);
    check("lf_col", 32'(cur_col), 32'd0);
    check("lf_row", 32'(cur_row), 32'd0);
    chk_burst("lf_clr", 0, 80);

    // Backspace at (4,0) and after 'x'
    for (int i = 0; i < 4; i++) send(8'h0A);
    send(8'h08);
    check("bs0_no_write", 32'(wr_en), 32'd0);
    check("bs0_col", 32'(cur_col), 32'd0);
    check("bs0_row", 32'(cur_row), 32'd4);
    send(8'h78);
    check("x_adr", 32'(wr_adr), 32'd320);
    check("x_data", 32'(data), 32'h78);
    check("x_col", 32'(cur_col), 32'd1);
    send(8'h08);
    check("bs_wr_en", 32'(wr_en), 32'd1);
    check("bs_adr", 32'(wr_adr), 32'd320);
    check("bs_data", 32'(data), 32'h00);
    check("bs_col", 32'(cur_col), 32'd0);
    check("bs_row", 32'(cur_row), 32'd4);

    // Clear pulsed with valid high in the middle of a row clear
    send(8'h0A);
    step();
    step();
    step();
    check("pre_clr_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    valid = 1'b1;
    chr   = 8'h5A;
    #1;
    check("clr_ready_low", 32'(ready), 32'd0);
    step();
    clear = 1'b0;
    valid = 1'b0;
    check("clr_col", 32'(cur_col), 32'd0);
    check("clr_row", 32'(cur_row), 32'd0);
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_no_write", 32'(wr_en), 32'd0);
    cnt  = 0;
    bad  = 0;
    lim  = 0;
    last = '0;
    while (busy && lim < 6000) begin
      step();
      lim++;
      if (wr_en) begin
        if (wr_adr !== 13'(cnt) || data !== 8'h00) bad++;
        last = wr_adr;
        cnt++;
      end
    end
    check("all_done", 32'(busy), 32'd0);
    check("all_count", 32'(cnt), 32'd4800);
    check("all_order", 32'(bad), 32'd0);
    check("all_last", 32'(last), 32'd4799);
    step();
    check("all_wr_en_after", 32'(wr_en), 32'd0);

    // Reset at the 1000th write of a full clear
    clear = 1'b1;
    step();
    clear = 1'b0;
    cnt = 0;
    lim = 0;
    while (cnt < 1000 && lim < 2000) begin
      step();
      lim++;
      if (wr_en) cnt++;
    end
    check("rst_mid_count", 32'(cnt), 32'd1000);
    check("rst_mid_adr", 32'(wr_adr), 32'd999);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wr_en", 32'(wr_en), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_col", 32'(cur_col), 32'd0);
    check("rst_mid_row", 32'(cur_row), 32'd0);
    check("rst_mid_wr_adr", 32'(wr_adr), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_rel_ready", 32'(ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (wr_en) cnt++;
      step();
    end
    check("rst_rel_no_writes", 32'(cnt), 32'd0);
    check("rst_rel_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
